// File: rtl/tl45_register_read.sv
// TL45 register-read stage: register file, operand forwarding, load-use
// hazard detection and the registered instruction buffer feeding the ALU.
module tl45_register_read (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_stall,
    output logic        o_pipe_flush,

    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [3:0]  i_sr1,
    input  logic [3:0]  i_sr2,
    input  logic [3:0]  i_jmp_cond,
    input  logic [31:0] i_imm,
    input  logic        i_use_imm,
    input  logic [31:0] i_target_offset,
    input  logic [31:0] i_pc,

    input  logic [3:0]  i_of1_reg,
    input  logic [31:0] i_of1_val,
    input  logic [3:0]  i_of2_reg,
    input  logic [31:0] i_of2_val,

    input  logic        i_mem_pending,
    input  logic [3:0]  i_mem_pending_reg,

    input  logic [3:0]  i_wb_reg,
    input  logic [31:0] i_wb_val,

    output logic [4:0]  o_opcode,
    output logic [3:0]  o_dr,
    output logic [3:0]  o_jmp_cond,
    output logic [31:0] o_sr1_val,
    output logic [31:0] o_sr2_val,
    output logic [31:0] o_target_offset,
    output logic [31:0] o_pc
);

    // Entry 0 exists only to keep indexing simple; it is pinned to zero.
    logic [31:0] regfile_q [16];
    logic [31:0] regfile_d [16];

    logic [4:0]  opcode_q, opcode_d;
    logic [3:0]  dr_q, dr_d;
    logic [3:0]  jmp_cond_q, jmp_cond_d;
    logic [31:0] sr1_val_q, sr1_val_d;
    logic [31:0] sr2_val_q, sr2_val_d;
    logic [31:0] target_offset_q, target_offset_d;
    logic [31:0] pc_q, pc_d;

    logic        hazard;
    logic [31:0] sr1_resolved;
    logic [31:0] sr2_resolved;

    // Youngest producer wins: ALU forward, then memory forward, then the
    // value being written back this very cycle, then the register file.
    // A forward port tagged with register 0 carries no result.
    function automatic logic [31:0] resolve_operand(
        input logic [3:0]  sel,
        input logic [31:0] rf_val,
        input logic [3:0]  of1_reg,
        input logic [31:0] of1_val,
        input logic [3:0]  of2_reg,
        input logic [31:0] of2_val,
        input logic [3:0]  wb_reg,
        input logic [31:0] wb_val
    );
        if (sel == 4'd0)
            return 32'd0;
        else if (of1_reg == sel)
            return of1_val;
        else if (of2_reg == sel)
            return of2_val;
        else if (wb_reg == sel)
            return wb_val;
        else
            return rf_val;
    endfunction

    // Writeback is unconditional on stall/flush; r0 never changes.
    always_comb begin
        for (int i = 0; i < 16; i++)
            regfile_d[i] = regfile_q[i];
        if (i_wb_reg != 4'd0)
            regfile_d[i_wb_reg] = i_wb_val;
        regfile_d[0] = 32'd0;
    end

    // Register file state.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 16; i++) begin
            if (i_reset)
                regfile_q[i] <= 32'd0;
            else
                regfile_q[i] <= regfile_d[i];
        end
    end

    // Load-use hazard: a pending load's destination is needed now. SR2 is
    // irrelevant when the immediate replaces it, and opcode 0 is a bubble.
    always_comb begin
        hazard = i_mem_pending
              && (i_mem_pending_reg != 4'd0)
              && ((i_sr1 == i_mem_pending_reg)
                  || (!i_use_imm && (i_sr2 == i_mem_pending_reg)))
              && (i_opcode != 5'd0);
    end

    // Operand selection for both sources.
    always_comb begin
        sr1_resolved = resolve_operand(i_sr1, regfile_q[i_sr1],
                                       i_of1_reg, i_of1_val,
                                       i_of2_reg, i_of2_val,
                                       i_wb_reg, i_wb_val);
        if (i_use_imm)
            sr2_resolved = i_imm;
        else
            sr2_resolved = resolve_operand(i_sr2, regfile_q[i_sr2],
                                           i_of1_reg, i_of1_val,
                                           i_of2_reg, i_of2_val,
                                           i_wb_reg, i_wb_val);
    end

    // Next buffer contents: flush > downstream stall > hazard bubble > load.
    always_comb begin
        opcode_d        = opcode_q;
        dr_d            = dr_q;
        jmp_cond_d      = jmp_cond_q;
        sr1_val_d       = sr1_val_q;
        sr2_val_d       = sr2_val_q;
        target_offset_d = target_offset_q;
        pc_d            = pc_q;
        if (i_pipe_flush || (!i_pipe_stall && hazard)) begin
            opcode_d        = 5'd0;
            dr_d            = 4'd0;
            jmp_cond_d      = 4'd0;
            sr1_val_d       = 32'd0;
            sr2_val_d       = 32'd0;
            target_offset_d = 32'd0;
            pc_d            = 32'd0;
        end else if (!i_pipe_stall) begin
            opcode_d        = i_opcode;
            dr_d            = i_dr;
            jmp_cond_d      = i_jmp_cond;
            sr1_val_d       = sr1_resolved;
            sr2_val_d       = sr2_resolved;
            target_offset_d = i_target_offset;
            pc_d            = i_pc;
        end
    end

    // Instruction buffer toward the ALU stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            opcode_q        <= 5'd0;
            dr_q            <= 4'd0;
            jmp_cond_q      <= 4'd0;
            sr1_val_q       <= 32'd0;
            sr2_val_q       <= 32'd0;
            target_offset_q <= 32'd0;
            pc_q            <= 32'd0;
        end else begin
            opcode_q        <= opcode_d;
            dr_q            <= dr_d;
            jmp_cond_q      <= jmp_cond_d;
            sr1_val_q       <= sr1_val_d;
            sr2_val_q       <= sr2_val_d;
            target_offset_q <= target_offset_d;
            pc_q            <= pc_d;
        end
    end

    assign o_pipe_stall    = i_pipe_stall || hazard;
    assign o_pipe_flush    = i_pipe_flush;
    assign o_opcode        = opcode_q;
    assign o_dr            = dr_q;
    assign o_jmp_cond      = jmp_cond_q;
    assign o_sr1_val       = sr1_val_q;
    assign o_sr2_val       = sr2_val_q;
    assign o_target_offset = target_offset_q;
    assign o_pc            = pc_q;

endmodule

// File: tb/tb_tl45_register_read.sv
// Directed bench for tl45_register_read with an expected-output queue.
module tb_tl45_register_read;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_pipe_stall, i_pipe_flush;
    logic        o_pipe_stall, o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond;
    logic [31:0] i_imm;
    logic        i_use_imm;
    logic [31:0] i_target_offset, i_pc;
    logic [3:0]  i_of1_reg, i_of2_reg;
    logic [31:0] i_of1_val, i_of2_val;
    logic        i_mem_pending;
    logic [3:0]  i_mem_pending_reg;
    logic [3:0]  i_wb_reg;
    logic [31:0] i_wb_val;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr, o_jmp_cond;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

    always #5 i_clk = ~i_clk;

    tl45_register_read dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
        .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
        .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_jmp_cond(i_jmp_cond), .i_imm(i_imm), .i_use_imm(i_use_imm),
        .i_target_offset(i_target_offset), .i_pc(i_pc),
        .i_of1_reg(i_of1_reg), .i_of1_val(i_of1_val),
        .i_of2_reg(i_of2_reg), .i_of2_val(i_of2_val),
        .i_mem_pending(i_mem_pending), .i_mem_pending_reg(i_mem_pending_reg),
        .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
        .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
        .o_target_offset(o_target_offset), .o_pc(o_pc)
    );

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  dr;
        logic [3:0]  jmp;
        logic [31:0] sr1v;
        logic [31:0] sr2v;
        logic [31:0] toff;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t zero_exp;
    int   checks   = 0;
    int   failures = 0;

    logic [140:0] outs;
    assign outs = {o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val,
                   o_target_offset, o_pc};

    function automatic exp_t mk(input logic [4:0] opc, input logic [3:0] dr,
                                input logic [3:0] jc, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] toff,
                                input logic [31:0] pc);
        exp_t e;
        e.opcode = opc; e.dr = dr; e.jmp = jc;
        e.sr1v = s1; e.sr2v = s2; e.toff = toff; e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [140:0] got,
                       input logic [140:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s got=no_expectation exp=queued_entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, outs, e);
        end
    endtask

    task automatic clr();
        i_pipe_stall = 0; i_pipe_flush = 0;
        i_opcode = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_jmp_cond = 0;
        i_imm = 0; i_use_imm = 0; i_target_offset = 0; i_pc = 0;
        i_of1_reg = 0; i_of1_val = 0; i_of2_reg = 0; i_of2_val = 0;
        i_mem_pending = 0; i_mem_pending_reg = 0;
        i_wb_reg = 0; i_wb_val = 0;
    endtask

    initial begin
        zero_exp = '0;
        clr();
        // Reset with live inputs and a flush request.
        i_reset = 1; i_opcode = 5'd1; i_sr1 = 4'd3; i_pc = 32'h44;
        i_wb_reg = 4'd3; i_wb_val = 32'h99; i_pipe_flush = 1;
        #1;
        chk_bit("reset_flush_comb", o_pipe_flush, 1'b1);
        push(zero_exp); tick("reset_0");
        i_pipe_flush = 0;
        push(zero_exp); tick("reset_1");
        i_reset = 0;

        // Writeback then read one cycle later.
        clr(); i_wb_reg = 4'd3; i_wb_val = 32'h11;
        push(zero_exp); tick("wb_r3");
        clr(); i_opcode = 5'd1; i_dr = 4'd2; i_sr1 = 4'd3;
        i_pc = 32'h100; i_target_offset = 32'h8;
        push(mk(5'd1, 4'd2, 4'd0, 32'h11, 32'h0, 32'h8, 32'h100));
        tick("rf_read_r3");

        // Forwarding priority.
        clr(); i_opcode = 5'd1; i_dr = 4'd5; i_sr1 = 4'd5;
        i_of1_reg = 4'd5; i_of1_val = 32'hAA;
        i_of2_reg = 4'd5; i_of2_val = 32'hBB;
        i_wb_reg  = 4'd5; i_wb_val  = 32'hCC;
        push(mk(5'd1, 4'd5, 4'd0, 32'hAA, 32'h0, 32'h0, 32'h0));
        tick("fwd_of1");
        i_of1_reg = 4'd0;
        push(mk(5'd1, 4'd5, 4'd0, 32'hBB, 32'h0, 32'h0, 32'h0));
        tick("fwd_of2");
        i_of2_reg = 4'd0; i_wb_val = 32'h5151;
        push(mk(5'd1, 4'd5, 4'd0, 32'h5151, 32'h0, 32'h0, 32'h0));
        tick("fwd_wb");
        clr(); i_opcode = 5'd1; i_sr1 = 4'd5; i_sr2 = 4'd5;
        push(mk(5'd1, 4'd0, 4'd0, 32'h5151, 32'h5151, 32'h0, 32'h0));
        tick("rf_read_r5");
        clr(); i_opcode = 5'd1; i_sr1 = 4'd6;
        i_of1_val = 32'hDEAD; i_of2_val = 32'hBEEF; i_wb_val = 32'h77;
        push(mk(5'd1, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        tick("fwd_reg0_nomatch");

        // r0 reads zero regardless of forwards and writes.
        clr(); i_opcode = 5'd1; i_sr1 = 4'd0;
        i_of1_reg = 4'd0; i_of1_val = 32'hFFFF;
        i_wb_reg = 4'd0; i_wb_val = 32'h55;
        push(zero_exp); push(mk(5'd1, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        void'(exp_q.pop_front());
        tick("r0_zero");
        clr(); i_opcode = 5'd1; i_sr2 = 4'd0; i_sr1 = 4'd0;
        push(mk(5'd1, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        tick("r0_after_wb");

        // Load-use hazard on SR2.
        clr(); i_opcode = 5'd2; i_dr = 4'd1; i_sr1 = 4'd1; i_sr2 = 4'd7;
        i_mem_pending = 1; i_mem_pending_reg = 4'd7;
        #1;
        chk_bit("hazard_stall", o_pipe_stall, 1'b1);
        i_opcode = 5'd0;
        #1;
        chk_bit("hazard_nop_opcode", o_pipe_stall, 1'b0);
        i_opcode = 5'd2;
        push(zero_exp); tick("hazard_bubble_0");
        push(zero_exp); tick("hazard_bubble_1");
        i_mem_pending = 0; i_of2_reg = 4'd7; i_of2_val = 32'h1234;
        #1;
        chk_bit("hazard_clear", o_pipe_stall, 1'b0);
        push(mk(5'd2, 4'd1, 4'd0, 32'h0, 32'h1234, 32'h0, 32'h0));
        tick("hazard_release_fwd");

        // Same pending load, but immediate replaces SR2.
        clr(); i_opcode = 5'd2; i_dr = 4'd1; i_sr1 = 4'd1; i_sr2 = 4'd7;
        i_use_imm = 1; i_imm = 32'h40;
        i_mem_pending = 1; i_mem_pending_reg = 4'd7;
        #1;
        chk_bit("imm_no_stall", o_pipe_stall, 1'b0);
        push(mk(5'd2, 4'd1, 4'd0, 32'h0, 32'h40, 32'h0, 32'h0));
        tick("imm_operand");

        // Downstream stall holds the buffer; writeback continues.
        clr(); i_opcode = 5'd3; i_dr = 4'd4; i_jmp_cond = 4'hA;
        i_sr1 = 4'd3; i_sr2 = 4'd5; i_target_offset = 32'h80; i_pc = 32'h200;
        push(mk(5'd3, 4'd4, 4'hA, 32'h11, 32'h5151, 32'h80, 32'h200));
        tick("load_before_stall");
        for (int i = 0; i < 5; i++) begin
            clr(); i_pipe_stall = 1;
            i_opcode = 5'(i + 4); i_sr1 = 4'(i + 1); i_pc = $urandom;
            i_dr = 4'd9; i_of1_reg = 4'd3; i_of1_val = $urandom;
            i_wb_reg = 4'd9; i_wb_val = 32'h99;
            if (i == 2) begin
                i_mem_pending = 1; i_mem_pending_reg = 4'(i + 1);
            end
            #1;
            chk_bit("stall_upstream", o_pipe_stall, 1'b1);
            push(last_exp); tick("stall_hold");
        end

        // Flush beats stall and hazard together.
        clr(); i_pipe_stall = 1; i_pipe_flush = 1;
        i_opcode = 5'd3; i_sr1 = 4'd3; i_mem_pending = 1; i_mem_pending_reg = 4'd3;
        #1;
        chk_bit("flush_comb", o_pipe_flush, 1'b1);
        push(zero_exp); tick("flush_zero");
        clr(); i_opcode = 5'd1; i_sr1 = 4'd9;
        push(mk(5'd1, 4'd0, 4'd0, 32'h99, 32'h0, 32'h0, 32'h0));
        tick("wb_during_stall");

        // Forward sampled only in the cycle the buffer loads.
        clr(); i_pipe_stall = 1; i_opcode = 5'd6; i_sr1 = 4'd4;
        i_of1_reg = 4'd4; i_of1_val = 32'h1;
        push(last_exp); tick("alu_stall_0");
        i_of1_val = 32'h3;
        push(last_exp); tick("alu_stall_1");
        i_pipe_stall = 0; i_of1_val = 32'h2;
        push(mk(5'd6, 4'd0, 4'd0, 32'h2, 32'h0, 32'h0, 32'h0));
        tick("alu_stall_release");

        // Reset in the middle of a hazard clears buffer and register file.
        clr(); i_opcode = 5'd2; i_sr1 = 4'd3;
        i_mem_pending = 1; i_mem_pending_reg = 4'd3;
        push(zero_exp); tick("pre_reset_hazard");
        i_reset = 1;
        push(zero_exp); tick("reset_mid_hazard");
        i_reset = 0;
        clr(); i_opcode = 5'd1; i_sr1 = 4'd3; i_sr2 = 4'd9;
        #1;
        chk_bit("post_reset_no_stall", o_pipe_stall, 1'b0);
        push(mk(5'd1, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        tick("post_reset_rf_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
